// File: rtl/carrier_gen_multi.sv
// Multi-channel carrier generator: per-channel programmable high/low phase lengths,
// boundary-synchronous duration reload, output polarity, common resync and end-of-period pulse.
module carrier_gen_multi #(
  parameter int TIMER_WIDTH = 16,
  parameter int NUM_CH      = 4
) (
  input  logic                          clk,
  input  logic                          sys_rst,
  input  logic [NUM_CH-1:0]             en,
  input  logic [NUM_CH*TIMER_WIDTH-1:0] high_dur,
  input  logic [NUM_CH*TIMER_WIDTH-1:0] low_dur,
  input  logic [NUM_CH-1:0]             polarity,
  input  logic                          sync,
  output logic [NUM_CH-1:0]             out,
  output logic [NUM_CH-1:0]             period_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  state_e                 state_q [NUM_CH];
  state_e                 state_d [NUM_CH];
  logic [TIMER_WIDTH-1:0] cnt_q   [NUM_CH];
  logic [TIMER_WIDTH-1:0] cnt_d   [NUM_CH];
  logic [TIMER_WIDTH-1:0] sh_lo_q [NUM_CH];
  logic [TIMER_WIDTH-1:0] sh_lo_d [NUM_CH];
  logic [NUM_CH-1:0]      wrap;
  logic [NUM_CH-1:0]      out_q, out_d;
  logic [NUM_CH-1:0]      pd_q, pd_d;

  // High-phase count is loaded straight from high_dur at the same boundary that
  // would capture its shadow, so only the low-phase shadow needs storage.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
        sh_lo_q[c] <= '0;
      end
      out_q <= '0;
      pd_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        sh_lo_q[c] <= sh_lo_d[c];
      end
      out_q <= out_d;
      pd_q  <= pd_d;
    end
  end

  always_comb begin
    wrap = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      sh_lo_d[c] = sh_lo_q[c];
      if (!en[c]) begin
        state_d[c] = ST_IDLE;
        cnt_d[c]   = '0;
      end else if (sync || state_q[c] == ST_IDLE) begin
        state_d[c] = ST_HIGH;
        cnt_d[c]   = high_dur[c*TIMER_WIDTH +: TIMER_WIDTH];
        sh_lo_d[c] = low_dur[c*TIMER_WIDTH +: TIMER_WIDTH];
      end else if (cnt_q[c] != '0) begin
        cnt_d[c] = cnt_q[c] - 1'b1;
      end else if (state_q[c] == ST_HIGH) begin
        state_d[c] = ST_LOW;
        cnt_d[c]   = sh_lo_q[c];
      end else begin
        state_d[c] = ST_HIGH;
        cnt_d[c]   = high_dur[c*TIMER_WIDTH +: TIMER_WIDTH];
        sh_lo_d[c] = low_dur[c*TIMER_WIDTH +: TIMER_WIDTH];
        wrap[c]    = 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      out_d[c] = (state_d[c] == ST_HIGH) ^ polarity[c];
    end
    pd_d = wrap;
  end

  assign out         = out_q;
  assign period_done = pd_q;

endmodule
